// File: rtl/popcount_seq.sv
// popcount_seq: multi-cycle population counter with threshold compare.
//
// Accepts a DATA_W-bit vector and a threshold through a valid/ready handshake.
// Counts the ones CHUNK_W bits per cycle, least significant chunk first.
// Presents the count and a threshold flag through an output valid/ready handshake.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   in_valid  - data_in/thresh valid
//   in_ready  - block can accept a vector (IDLE)
//   data_in   - vector to count
//   thresh    - flip threshold, captured with data_in
//   out_valid - sum/over_thr valid (DONE)
//   out_ready - consumer accepts the result
//   sum       - number of ones in the captured vector
//   over_thr  - 1 when sum >= captured threshold
//   busy      - state is RUN or DONE
module popcount_seq #(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned CHUNK_W = 32,
    localparam int unsigned SUM_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [SUM_W-1:0]  thresh,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  sum,
    output logic              over_thr,
    output logic              busy
);

    localparam int unsigned NCHUNK = DATA_W / CHUNK_W;
    localparam int unsigned CNT_W  = $clog2(CHUNK_W + 1);
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [IDX_W-1:0] IdxLast = IDX_W'(NCHUNK - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SUM_W-1:0]  thr_q, thr_d;
    logic [SUM_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              over_q, over_d;
    logic              out_valid_q, out_valid_d;

    logic [CNT_W-1:0]  chunk_cnt;
    logic [SUM_W-1:0]  acc_next;

    // The data register shifts right by one chunk per RUN cycle, so the chunk
    // being counted is always the low CHUNK_W bits.
    always_comb begin
        chunk_cnt = '0;
        for (int unsigned i = 0; i < CHUNK_W; i++) begin
            chunk_cnt = chunk_cnt + CNT_W'(data_q[i]);
        end
    end

    assign acc_next = acc_q + SUM_W'(chunk_cnt);

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        thr_d       = thr_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        over_d      = over_q;
        out_valid_d = out_valid_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    data_d  = data_in;
                    thr_d   = thresh;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d  = acc_next;
                idx_d  = idx_q + 1'b1;
                data_d = data_q >> CHUNK_W;
                if (idx_q == IdxLast) begin
                    state_d     = StDone;
                    sum_d       = acc_next;
                    over_d      = (acc_next >= thr_q);
                    out_valid_d = 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            data_q      <= '0;
            thr_q       <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            over_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            thr_q       <= thr_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            over_q      <= over_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign over_thr  = over_q;

endmodule

// File: tb/tb_popcount_seq.sv
// Testbench for popcount_seq: default instance (128/32) plus 64/8 and 16/16 instances.
module tb_popcount_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic         iv_a = 1'b0, ir_a, ov_a, or_a = 1'b1, ot_a, bz_a;
    logic [127:0] d_a = '0;
    logic [7:0]   t_a = '0, s_a;
    // 64/8 instance
    logic         iv_b = 1'b0, ir_b, ov_b, or_b = 1'b1, ot_b, bz_b;
    logic [63:0]  d_b = '0;
    logic [6:0]   t_b = '0, s_b;
    // 16/16 instance
    logic         iv_c = 1'b0, ir_c, ov_c, or_c = 1'b1, ot_c, bz_c;
    logic [15:0]  d_c = '0;
    logic [4:0]   t_c = '0, s_c;

    popcount_seq #(.DATA_W(128), .CHUNK_W(32)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .data_in(d_a),
        .thresh(t_a), .out_valid(ov_a), .out_ready(or_a), .sum(s_a), .over_thr(ot_a),
        .busy(bz_a)
    );
    popcount_seq #(.DATA_W(64), .CHUNK_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .data_in(d_b),
        .thresh(t_b), .out_valid(ov_b), .out_ready(or_b), .sum(s_b), .over_thr(ot_b),
        .busy(bz_b)
    );
    popcount_seq #(.DATA_W(16), .CHUNK_W(16)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(ir_c), .data_in(d_c),
        .thresh(t_c), .out_valid(ov_c), .out_ready(or_c), .sum(s_c), .over_thr(ot_c),
        .busy(bz_c)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic get_ready(input int w);
        return (w == 0) ? ir_a : (w == 1) ? ir_b : ir_c;
    endfunction
    function automatic logic get_valid(input int w);
        return (w == 0) ? ov_a : (w == 1) ? ov_b : ov_c;
    endfunction
    function automatic int get_sum(input int w);
        return (w == 0) ? int'(s_a) : (w == 1) ? int'(s_b) : int'(s_c);
    endfunction
    function automatic logic get_over(input int w);
        return (w == 0) ? ot_a : (w == 1) ? ot_b : ot_c;
    endfunction

    task automatic drive(input int w, input logic v, input logic [127:0] d, input int thr);
        case (w)
            0: begin iv_a = v; d_a = d; t_a = 8'(thr); end
            1: begin iv_b = v; d_b = d[63:0]; t_b = 7'(thr); end
            default: begin iv_c = v; d_c = d[15:0]; t_c = 5'(thr); end
        endcase
    endtask

    // Send one vector with out_ready high; return result and accept-to-valid latency.
    task automatic run_vec(input int w, input logic [127:0] d, input int thr,
                           output int s, output logic o, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!get_ready(w) && n < 100) begin
            @(negedge clk);
            n++;
        end
        drive(w, 1'b1, d, thr);
        @(negedge clk);
        // Scramble inputs after the accept edge; the result must not depend on them.
        drive(w, 1'b0, {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 31)));
        lat = 0;
        while (!get_valid(w) && lat < 100) begin
            lat++;
            @(negedge clk);
        end
        s = get_sum(w);
        o = get_over(w);
    endtask

    typedef struct {
        logic [127:0] data;
        int           thr;
        int           exp_sum;
        logic         exp_over;
    } vec_t;

    vec_t tbl[8];
    int   s, lat, got, k, last;
    logic o;
    int   exp_q[$];
    logic [127:0] rv;
    int   rt, rc;

    initial begin
        tbl[0] = '{128'h0, 1, 0, 1'b0};
        tbl[1] = '{{128{1'b1}}, 128, 128, 1'b1};
        tbl[2] = '{128'h8000_0000_8000_0000_0000_0001_8000_0000, 5, 4, 1'b0};
        tbl[3] = '{128'h8000_0000_8000_0000_0000_0001_8000_0000, 4, 4, 1'b1};
        tbl[4] = '{128'h1, 0, 1, 1'b1};
        tbl[5] = '{{128{1'b1}}, 129, 128, 1'b0};
        tbl[6] = '{128'hFF, 8, 8, 1'b1};
        tbl[7] = '{128'h0000_0001_0000_0001_0000_0001_0000_0001, 3, 4, 1'b1};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", ir_a, 1);
        check("rst_out_valid", ov_a, 0);
        check("rst_sum", s_a, 0);
        check("rst_busy", bz_a, 0);
        rst_n = 1'b1;

        // Table-driven vectors on the default instance
        for (int i = 0; i < 8; i++) begin
            run_vec(0, tbl[i].data, tbl[i].thr, s, o, lat);
            check($sformatf("tbl%0d_sum", i), s, tbl[i].exp_sum);
            check($sformatf("tbl%0d_over", i), o, tbl[i].exp_over);
            check($sformatf("tbl%0d_lat", i), lat, 4);
        end

        // Randomized vectors against $countones reference
        for (int i = 0; i < 30; i++) begin
            rv = {$urandom, $urandom, $urandom, $urandom};
            if (i % 3 == 1) rv = rv & {$urandom, $urandom, $urandom, $urandom};
            rt = int'($urandom_range(0, 140));
            rc = $countones(rv);
            run_vec(0, rv, rt, s, o, lat);
            check($sformatf("rnd%0d_sum", i), s, rc);
            check($sformatf("rnd%0d_over", i), o, (rc >= (rt % 256)));
        end

        // Reset mid-RUN with all ones loaded, after a nonzero result was left in sum
        @(negedge clk);
        drive(0, 1'b1, {128{1'b1}}, 3);
        @(negedge clk);
        drive(0, 1'b0, '0, 0);
        @(negedge clk);
        check("midrun_busy_before", bz_a, 1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", ov_a, 0);
        check("midrun_rst_sum", s_a, 0);
        check("midrun_rst_in_ready", ir_a, 1);
        check("midrun_rst_busy", bz_a, 0);
        check("midrun_rst_over", ot_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0, 128'h1, 1, s, o, lat);
        check("post_rst_sum", s, 1);
        check("post_rst_lat", lat, 4);

        // Output backpressure
        @(negedge clk);
        or_a = 1'b0;
        drive(0, 1'b1, {64'h0, {64{1'b1}}}, 64);
        @(negedge clk);
        drive(0, 1'b0, '0, 0);
        lat = 0;
        while (!ov_a && lat < 100) begin
            lat++;
            @(negedge clk);
        end
        check("bp_lat", lat, 4);
        for (int i = 0; i < 10; i++) begin
            drive(0, i[0], 128'h7, 0);
            @(negedge clk);
            check($sformatf("bp_hold%0d", i), {ov_a, ir_a, ot_a, s_a}, {1'b1, 1'b0, 1'b1, 8'd64});
        end
        drive(0, 1'b0, '0, 0);
        or_a = 1'b1;
        @(negedge clk);
        check("bp_release_valid", ov_a, 0);
        check("bp_release_ready", ir_a, 1);
        run_vec(0, 128'h3, 2, s, o, lat);
        check("bp_next_sum", s, 2);
        check("bp_next_over", o, 1);

        // Back-to-back: in_valid held high with counter vectors 0..19
        k = 0;
        last = -1;
        got = 0;
        exp_q.delete();
        for (int c = 0; c < 400 && got < 20; c++) begin
            @(negedge clk);
            if (ov_a) begin
                rc = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                check($sformatf("b2b%0d_sum", got), s_a, $countones(rc));
                check($sformatf("b2b%0d_over", got), ot_a, ($countones(rc) >= 2));
                got++;
            end
            if (ir_a) begin
                if (k < 20) begin
                    drive(0, 1'b1, 128'(k), 2);
                    exp_q.push_back(k);
                    if (last >= 0) check($sformatf("b2b%0d_space", k), c - last, 6);
                    last = c;
                    k++;
                end else begin
                    drive(0, 1'b0, '0, 0);
                end
            end
        end
        drive(0, 1'b0, '0, 0);
        check("b2b_count", got, 20);

        // 64/8 instance
        run_vec(1, {64'h0, {64{1'b1}}}, 64, s, o, lat);
        check("p64_ones_sum", s, 64);
        check("p64_ones_over", o, 1);
        check("p64_lat", lat, 8);
        for (int i = 0; i < 5; i++) begin
            rv = {64'h0, $urandom, $urandom};
            rt = int'($urandom_range(0, 70));
            rc = $countones(rv);
            run_vec(1, rv, rt, s, o, lat);
            check($sformatf("p64_rnd%0d_sum", i), s, rc);
            check($sformatf("p64_rnd%0d_over", i), o, (rc >= (rt % 128)));
        end

        // 16/16 instance
        run_vec(2, 128'hA5A5, 8, s, o, lat);
        check("p16_sum", s, 8);
        check("p16_over", o, 1);
        check("p16_lat", lat, 1);
        run_vec(2, 128'hA5A5, 9, s, o, lat);
        check("p16_over_hi", o, 0);
        run_vec(2, 128'hFFFF, 17, s, o, lat);
        check("p16_ones_sum", s, 16);
        check("p16_ones_over", o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/popcount_seq.md
# popcount_seq

Parametrised, multi-cycle population counter with threshold compare for the LDPC bit-flipping datapath. It accepts a DATA_W-bit vector through a valid/ready handshake and counts its ones CHUNK_W bits per cycle. It then presents the count and a threshold flag through an output valid/ready handshake. It succeeds the fixed 128-bit combinational bit adder and is used to count unsatisfied checks per variable node and to compare the count against the flip threshold.

## Interface
- DATA_W, 128: input vector width; must be a multiple of CHUNK_W.
- CHUNK_W, 32: bits counted per cycle; 1 ≤ CHUNK_W ≤ DATA_W.
- NCHUNK (local), DATA_W/CHUNK_W: number of counting cycles.
- SUM_W (local), $clog2(DATA_W+1): count width; 8 for DATA_W=128.

- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  data_in/thresh valid.
- in_ready  out  1  block can accept a vector.
- data_in  in  DATA_W  vector to count.
- thresh  in  SUM_W  flip threshold, captured together with data_in.
- out_valid  out  1  sum/over_thr valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  SUM_W  number of ones in the captured vector.
- over_thr  out  1  1 when sum ≥ captured thresh.
- busy  out  1  state is RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready:
  - capture data_in into a shift/data register and thresh into a threshold register;
  - set acc=0 and chunk index idx=0;
  - go to RUN.
- RUN: each cycle, acc += popcount(data_reg[idx*CHUNK_W +: CHUNK_W]) and idx++.
  - Chunk 0 is bits [CHUNK_W-1:0], counted first (LSB chunk first).
  - On the cycle idx == NCHUNK-1, the final add is performed and the state goes to DONE.
- DONE: out_valid=1. sum=acc; over_thr=(acc ≥ thr_reg), compared unsigned at SUM_W bits.
  - On out_ready, go to IDLE.
  - While out_ready=0, hold sum, over_thr and out_valid stable.
- in_ready is 0 in RUN and DONE. in_valid in those states is ignored and nothing is captured.
- Arithmetic:
  - The per-chunk popcount is combinational, with width $clog2(CHUNK_W+1).
  - The accumulator is SUM_W wide and cannot overflow, because the maximum value DATA_W fits in SUM_W.
- thresh=0 always gives over_thr=1. thresh > DATA_W always gives over_thr=0.
- data_in and thresh may change freely after the accept edge; the result depends only on the captured values.
- Reset, at any time including mid-RUN or in DONE with a result pending:
  - state=IDLE, in_ready=1, out_valid=0, sum=0, over_thr=0, busy=0;
  - acc, idx, data and threshold registers are cleared to 0;
  - any in-flight vector is discarded.
- Release of rst_n is used synchronously. The first accept is possible on the first rising edge with rst_n high.

## Timing
- Accept edge at cycle T (IDLE, in_valid=1).
- RUN occupies cycles T+1 … T+NCHUNK. out_valid rises after edge T+NCHUNK, giving latency NCHUNK cycles from accept to out_valid (4 for the defaults).
- With out_ready held high, DONE lasts exactly 1 cycle.
- IDLE follows the next edge, and in_ready is high one cycle after the result handshake.
- Best-case throughput: one vector per NCHUNK+2 cycles.
- Outputs are registered: sum, over_thr and out_valid come from flops, and in_ready and busy decode from the state register.
- Degenerate CHUNK_W=DATA_W (NCHUNK=1): RUN lasts one cycle and the latency is 1.

## Test plan
- **Reset values:** assert rst_n=0 mid-RUN with 0xFFFF…F loaded.
  - During reset: out_valid=0, sum=0, in_ready=1, busy=0.
  - After release: the next vector 0x1 gives sum=1, with no residue from the aborted count.
- **Extremes (defaults):**
  - data_in=0, thresh=1 → sum=0, over_thr=0.
  - data_in=all ones, thresh=128 → sum=128 (8'h80), over_thr=1.
  - Both results appear exactly 4 cycles after the accept edge.
- **Chunk boundaries:**
  - data_in with only bits 31, 32, 95, 127 set, thresh=5 → sum=4, over_thr=0.
  - Same vector with thresh=4 → over_thr=1.
- **Output backpressure:**
  - Result sum=64 with out_ready=0 for 10 cycles: out_valid, sum and over_thr remain stable.
  - in_ready stays 0 and in_valid pulses are ignored.
  - Raising out_ready returns the block to IDLE after one edge.
- **Back-to-back traffic:**
  - in_valid held high with an incrementing counter vector 0…19 and out_ready=1.
  - Each sum equals the reference popcount of the counter value.
  - Accepts are spaced exactly 6 cycles apart.
- **Parametrisation:**
  - DATA_W=64, CHUNK_W=8: SUM_W=7, latency 8; all ones gives sum=64.
  - DATA_W=CHUNK_W=16: latency 1; 0xA5A5 gives sum=8.
